// File: rtl/sprite_anim_engine.sv
// sprite_anim_engine: positioned, 2^n-scaled, flippable, animated sprite.
// Optional macro SPRITE_VFLIP_EN adds a shadowed flip_v (row mirror) input.
module sprite_anim_engine #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = $clog2(FRAMES*SPR_W*SPR_H)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic                      frame_start,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  input  logic                      flip_h,
`ifdef SPRITE_VFLIP_EN
  input  logic                      flip_v,
`endif
  input  logic                      anim_loop,
  input  logic                      play,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [IDX_W-1:0]          rom_q,
  output logic [IDX_W-1:0]          pix_idx,
  output logic                      pix_opaque,
  output logic [$clog2(FRAMES)-1:0] cur_frame,
  output logic                      anim_done
);

  localparam int TXW = $clog2(SPR_W);
  localparam int TYW = $clog2(SPR_H);
  localparam int FW  = $clog2(FRAMES);
  localparam int HW  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);

  localparam logic [FW-1:0]    LAST_FRAME = FW'(FRAMES - 1);
  localparam logic [HW-1:0]    LAST_HOLD  = HW'(FRAME_HOLD - 1);
  localparam logic [IDX_W-1:0] TRANSP     = IDX_W'(TRANSP_IDX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [FW-1:0]   frame_q;
  logic [FW-1:0]   frame_d;
  logic [HW-1:0]   hold_q;
  logic [HW-1:0]   hold_d;

  logic [9:0]      sx0;
  logic [9:0]      sy0;
  logic            sflip_h;
  logic            sflip_v;

  logic [10:0]     x11;
  logic [10:0]     y11;
  logic [10:0]     sx11;
  logic [10:0]     sy11;
  logic [10:0]     dx;
  logic [10:0]     dy;
  logic            hit;
  logic [TXW-1:0]  tx;
  logic [TXW-1:0]  txf;
  logic [TYW-1:0]  ty;
  logic [TYW-1:0]  tyf;
  logic [ADDR_W-1:0] addr_d;

  logic            hit_d1;
  logic            hit_d2;

  // Position/flip only change at frame_start, so a frame never tears.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx0     <= '0;
      sy0     <= '0;
      sflip_h <= 1'b0;
      sflip_v <= 1'b0;
    end else if (frame_start) begin
      sx0     <= pos_x;
      sy0     <= pos_y;
      sflip_h <= flip_h;
`ifdef SPRITE_VFLIP_EN
      sflip_v <= flip_v;
`else
      sflip_v <= 1'b0;
`endif
    end
  end

  // Hit test and texel address; frame/row/col are power-of-two fields.
  always_comb begin
    x11    = {1'b0, DrawX};
    y11    = {1'b0, DrawY};
    sx11   = {1'b0, sx0};
    sy11   = {1'b0, sy0};
    dx     = x11 - sx11;
    dy     = y11 - sy11;
    hit    = blank
           && (x11 >= sx11) && (x11 < sx11 + SPAN_X)
           && (y11 >= sy11) && (y11 < sy11 + SPAN_Y);
    tx     = TXW'(dx >> SCALE_LOG2);
    ty     = TYW'(dy >> SCALE_LOG2);
    txf    = sflip_h ? (TXW'(SPR_W - 1) - tx) : tx;
    tyf    = sflip_v ? (TYW'(SPR_H - 1) - ty) : ty;
    addr_d = ADDR_W'({frame_q, tyf, txf});
  end

  // Address stage, ROM wait stage, then index/opaque output stage.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      hit_d1      <= 1'b0;
      hit_d2      <= 1'b0;
      pix_idx     <= '0;
      pix_opaque  <= 1'b0;
    end else begin
      if (hit) begin
        rom_address <= addr_d;
      end
      hit_d1     <= hit;
      hit_d2     <= hit_d1;
      pix_idx    <= hit_d2 ? rom_q : '0;
      pix_opaque <= hit_d2 && (rom_q != TRANSP);
    end
  end

  // Animation state register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
    end
  end

  // Next state: play always restarts and beats a coincident frame_start.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    if (play) begin
      state_d = S_PLAY;
      frame_d = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          frame_d = '0;
          hold_d  = '0;
        end
        S_PLAY: begin
          if (frame_start) begin
            if (hold_q == LAST_HOLD) begin
              hold_d = '0;
              if (frame_q == LAST_FRAME) begin
                if (anim_loop) begin
                  frame_d = '0;
                end else begin
                  state_d = S_DONE;
                end
              end else begin
                frame_d = frame_q + 1'b1;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          frame_d = frame_q;
        end
        default: begin
          state_d = S_IDLE;
          frame_d = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign cur_frame = frame_q;
  assign anim_done = (state_q == S_DONE);

endmodule
